debug_dump_ctrl: RTL and testbench

DEBUG_DUMP_CTRL -- requirements
Module: debug_dump_ctrl

---
 rtl/dbg_pkg.sv | 18 +
 rtl/debug_dump_ctrl.sv | 128 ++++++++++++
 tb/tb_debug_dump_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared types for the debug dump controller: FSM states and halt reasons.
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } dbg_state_e;

    typedef enum logic [1:0] {
        HALT_NONE   = 2'd0,
        HALT_LIMIT  = 2'd1,
        HALT_EXCEPT = 2'd2,
        HALT_ABORT  = 2'd3
    } halt_cause_e;

endpackage

// File: rtl/debug_dump_ctrl.sv
// Runs the core for a bounded number of cycles, then streams every
// architectural register out over a valid/ready dump channel.
module debug_dump_ctrl
    import dbg_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int CYC_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CYC_W-1:0]         cycle_limit,
    input  logic                     except,
    output logic                     core_run,
    output logic [$clog2(NREGS)-1:0] reg_idx,
    input  logic [XLEN-1:0]          reg_data,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [$clog2(NREGS)-1:0] dump_idx,
    output logic [XLEN-1:0]          dump_data,
    output logic                     dump_last,
    output logic                     done,
    output logic [1:0]               halt_cause,
    output logic [CYC_W-1:0]         cycles
);

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    dbg_state_e        state_q, state_d;
    halt_cause_e       cause_q, cause_d;
    logic [CYC_W-1:0]  limit_q, limit_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              lastBeat;

    assign lastBeat   = (idx_q == LAST_IDX);
    assign halt_cause = cause_q;
    assign cycles     = cycles_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cause_q  <= HALT_NONE;
            limit_q  <= '0;
            cycles_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            limit_q  <= limit_d;
            cycles_q <= cycles_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        limit_d    = limit_q;
        cycles_d   = cycles_q;
        idx_d      = idx_q;
        core_run   = 1'b0;
        dump_valid = 1'b0;
        dump_last  = 1'b0;
        dump_idx   = '0;
        dump_data  = '0;
        reg_idx    = '0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    limit_d  = cycle_limit;
                    cycles_d = '0;
                    cause_d  = HALT_NONE;
                    idx_d    = '0;
                    // A zero budget never lets the core step; go straight to the dump.
                    if (cycle_limit == '0) begin
                        cause_d = HALT_LIMIT;
                        state_d = ST_DUMP;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                core_run = 1'b1;
                cycles_d = cycles_q + CYC_W'(1);
                idx_d    = '0;
                if (except) begin
                    cause_d = HALT_EXCEPT;
                    state_d = ST_DUMP;
                end else if (abort) begin
                    cause_d = HALT_ABORT;
                    state_d = ST_DUMP;
                end else if (cycles_d == limit_q) begin
                    cause_d = HALT_LIMIT;
                    state_d = ST_DUMP;
                end
            end

            ST_DUMP: begin
                dump_valid = 1'b1;
                reg_idx    = idx_q;
                dump_idx   = idx_q;
                dump_data  = reg_data;
                dump_last  = lastBeat;
                if (dump_ready) begin
                    if (lastBeat) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Randomized self-checking bench for debug_dump_ctrl; each run is predicted
// from the run-length/priority rules and the dump stream is scoreboarded.
module tb_debug_dump_ctrl;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int CYC_W = 32;
    localparam int BUDGET = 3000;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CYC_W-1:0] cycle_limit;
    logic             except;
    logic             core_run;
    logic [4:0]       reg_idx;
    logic [XLEN-1:0]  reg_data;
    logic             dump_valid;
    logic             dump_ready;
    logic [4:0]       dump_idx;
    logic [XLEN-1:0]  dump_data;
    logic             dump_last;
    logic             done;
    logic [1:0]       halt_cause;
    logic [CYC_W-1:0] cycles;

    logic [XLEN-1:0]  regs [NREGS];
    int               errCount = 0;
    int               checkCount = 0;

    assign reg_data = regs[reg_idx];

    always #5 clock = ~clock;

    debug_dump_ctrl #(.XLEN(XLEN), .NREGS(NREGS), .CYC_W(CYC_W)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .cycle_limit(cycle_limit), .except(except), .core_run(core_run),
        .reg_idx(reg_idx), .reg_data(reg_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_last(dump_last), .done(done), .halt_cause(halt_cause),
        .cycles(cycles)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checkCount++;
        if (got !== want) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".core_run"}, 64'(core_run), 64'd0);
        checkOutput({tag, ".dump_valid"}, 64'(dump_valid), 64'd0);
        checkOutput({tag, ".dump_last"}, 64'(dump_last), 64'd0);
        checkOutput({tag, ".dump_idx"}, 64'(dump_idx), 64'd0);
        checkOutput({tag, ".dump_data"}, dump_data, 64'd0);
        checkOutput({tag, ".reg_idx"}, 64'(reg_idx), 64'd0);
        checkOutput({tag, ".done"}, 64'(done), 64'd0);
        checkOutput({tag, ".halt_cause"}, 64'(halt_cause), 64'd0);
        checkOutput({tag, ".cycles"}, 64'(cycles), 64'd0);
    endtask

    // One complete run and dump. excAt/abtAt name the RUN cycle (1-based)
    // in which that flag is raised, 0 meaning never. readyMode: 0 always
    // ready, 1 the 1,0,0 repeating pattern, 2 random.
    task automatic applyStimulus(input int lim, input int excAt, input int abtAt, input int readyMode);
        int          expLen, expCause, runCnt, beat, budget, pat;
        logic        holdValid;
        logic [4:0]  holdIdx;
        logic [63:0] holdData;
        logic        r;

        expLen = lim;
        expCause = 1;
        for (int k = 1; k <= lim; k++) begin
            if (k == excAt) begin expLen = k; expCause = 2; break; end
            if (k == abtAt) begin expLen = k; expCause = 3; break; end
        end

        runCnt = 0; beat = 0; budget = 0; pat = 0; holdValid = 1'b0;
        holdIdx = '0; holdData = '0;

        cycle_limit = CYC_W'(lim);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycle_limit = $urandom;
        checkOutput("doneCleared", 64'(done), 64'd0);
        checkOutput("cyclesCleared", 64'(cycles), 64'd0);

        while (!done && budget < BUDGET) begin
            except = 1'b0;
            abort  = 1'b0;
            if (core_run) begin
                runCnt++;
                except = (runCnt == excAt);
                abort  = (runCnt == abtAt);
                start  = $urandom_range(0, 1);
            end else begin
                except = $urandom_range(0, 1);
                abort  = $urandom_range(0, 1);
            end

            if (dump_valid) begin
                start = $urandom_range(0, 1);
                if (core_run) checkOutput("runInDump", 64'(core_run), 64'd0);
                if (dump_idx != reg_idx) checkOutput("regIdxInDump", 64'(reg_idx), 64'(dump_idx));
                if (holdValid) begin
                    checkOutput("stableIdx", 64'(dump_idx), 64'(holdIdx));
                    checkOutput("stableData", dump_data, holdData);
                end
                case (readyMode)
                    0: r = 1'b1;
                    1: r = (pat % 3 == 0);
                    default: r = $urandom_range(0, 1);
                endcase
                pat++;
                dump_ready = r;
                if (r) begin
                    checkOutput("beatIdx", 64'(dump_idx), 64'(beat % NREGS));
                    checkOutput("beatData", dump_data, regs[beat % NREGS]);
                    checkOutput("beatLast", 64'(dump_last), 64'(beat == NREGS - 1));
                    beat++;
                    holdValid = 1'b0;
                end else begin
                    holdValid = 1'b1;
                    holdIdx = dump_idx;
                    holdData = dump_data;
                end
            end else begin
                dump_ready = $urandom_range(0, 1);
                if (reg_idx != 0) checkOutput("regIdxOutsideDump", 64'(reg_idx), 64'd0);
            end
            tick();
            budget++;
        end
        start = 1'b0;
        except = 1'b0;
        abort = 1'b0;

        checkOutput("reachedDone", 64'(done), 64'd1);
        checkOutput("runLength", 64'(runCnt), 64'(expLen));
        checkOutput("beatCount", 64'(beat), 64'(NREGS));
        checkOutput("haltCause", 64'(halt_cause), 64'(expCause));
        checkOutput("cyclesCount", 64'(cycles), 64'(expLen));
        checkOutput("doneNoValid", 64'(dump_valid), 64'd0);
        checkOutput("doneNoRun", 64'(core_run), 64'd0);

        // Stray flags in DONE must not disturb the held result.
        except = 1'b1;
        abort = 1'b1;
        tick();
        except = 1'b0;
        abort = 1'b0;
        checkOutput("doneHold", 64'(done), 64'd1);
        checkOutput("causeHold", 64'(halt_cause), 64'(expCause));
        checkOutput("cyclesHold", 64'(cycles), 64'(expLen));
    endtask

    task automatic resetMidDump();
        int budget;
        budget = 0;
        cycle_limit = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        dump_ready = 1'b1;
        while (!(dump_valid && dump_idx == 5'd10) && budget < 200) begin
            tick();
            budget++;
        end
        checkOutput("reachedBeat10", 64'(dump_idx), 64'd10);
        reset = 1'b1;
        start = 1'b1;
        cycle_limit = 32'd3;
        tick();
        checkIdleOutputs("midDumpReset");
        reset = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("postReset.core_run", 64'(core_run), 64'd0);
        checkOutput("postReset.dump_valid", 64'(dump_valid), 64'd0);
        checkOutput("postReset.done", 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; except = 1'b0;
        cycle_limit = '0; dump_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom};

        start = 1'b1;
        repeat (3) tick();
        checkIdleOutputs("reset");
        reset = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("idleAfterReset", 64'(core_run), 64'd0);

        applyStimulus(5, 0, 0, 0);
        applyStimulus(100, 3, 0, 2);
        for (int i = 0; i < NREGS; i++) regs[i] = 64'(i) * 64'h1111;
        applyStimulus(4, 0, 0, 1);
        applyStimulus(6, 6, 6, 2);
        applyStimulus(0, 0, 0, 2);
        applyStimulus(2, 0, 0, 0);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom};
            applyStimulus($urandom_range(0, 12), $urandom_range(0, 15),
                          $urandom_range(0, 15), $urandom_range(0, 2));
        end

        resetMidDump();
        applyStimulus(3, 0, 2, 2);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
